opl_stat_regs: RTL
==================

Name: opl_stat_regs

Overview:
- Parametrised successor to the per-module CPU register block.
- Provides NUM_CNT wide event/byte counters, read as 64-bit values with a low-word snapshot, plus NUM_RW byte-enabled R/W control registers.
- Sits in the IP clock domain behind the existing cpu_sync IPIF-style handshake, one instance per datapath module.
- Clear-on-read is selectable per counter, and unmapped accesses return an error.

Parameters:
- ADDR_WIDTH, 12: local byte-offset width of bus2ip_addr.
- NUM_CNT, 8: number of counters, 1..32.
- CNT_WIDTH, 48: counter width, 1..64.
- INC_WIDTH, 16: per-counter increment width, must be ≤ CNT_WIDTH.
- CLR_ON_READ, {32{1'b1}}: bit i=1 means counter i clears when its low word is read.
- NUM_RW, 4: number of R/W registers, 1..64.
- RW_DEFAULT, 32'h0: reset value of every R/W register.
- ID_VALUE, 32'h0: constant returned at offset 0x000.
- VERSION_VALUE, 32'h1: constant returned at offset 0x004.

Ports:
- clk  in  1  IP clock.
- reset  in  1  synchronous, active-high reset.
- bus2ip_cs  in  1  transaction request; held high until acked.
- bus2ip_rnw  in  1  1=read, 0=write.
- bus2ip_addr  in  ADDR_WIDTH  byte offset; bits [1:0] are ignored.
- bus2ip_data  in  32  write data.
- bus2ip_be  in  4  write byte enables.
- ip2bus_data  out  32  read data.
- ip2bus_rdack  out  1  one-cycle read acknowledge.
- ip2bus_wrack  out  1  one-cycle write acknowledge.
- ip2bus_error  out  1  one-cycle error, coincident with the ack.
- cnt_inc  in  NUM_CNT  increment strobe per counter.
- cnt_inc_val  in  NUM_CNT*INC_WIDTH  increment amount; counter i uses slice i.
- cnt_value  out  NUM_CNT*CNT_WIDTH  live counter values.
- rw_reg  out  NUM_RW*32  R/W register contents.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high.
- Reset values:
  - ip2bus_data=32'hDEADBEEF.
  - ip2bus_rdack, ip2bus_wrack, ip2bus_error=0.
  - All counters and the snapshot register =0.
  - rw_reg=RW_DEFAULT per register.
  - Armed flag=1.
- Address map (byte offsets):
  - 0x000 ID (RO).
  - 0x004 VERSION (RO).
  - 0x008 CNT_CLR (WO): each written 1 clears the counter with that bit index; byte enables apply.
  - 0x100+8*i: counter i low word (bits [31:0]).
  - 0x104+8*i: counter i high word (snapshot).
  - 0x200+4*j: R/W register j.
  - Any other offset, or an index ≥ NUM_CNT/NUM_RW, is unmapped.
- Handshake:
  - An ack is issued when bus2ip_cs=1 and armed=1.
  - The ack appears the cycle after that condition is sampled (1-cycle latency) and is a single-cycle pulse.
  - armed clears with the ack and re-sets only after bus2ip_cs is sampled low.
  - Exactly one ack and one set of side effects occur per transaction, regardless of how long cs is held.
- Reads:
  - ip2bus_data is registered in the same cycle as rdack.
  - Unmapped read: data=32'hDEADBEEF and error=1.
  - Reading a write-only location returns 0, no error.
- Counter low-word read:
  - Returns the value as it stood before this cycle's increment.
  - The same cycle latches bits [63:32] of that value into the single shared snapshot register; bits above CNT_WIDTH read 0.
  - If CLR_ON_READ[i], the counter is cleared in that same cycle.
- High-word read:
  - Returns the snapshot, with no side effect.
  - The snapshot is shared: software must read low then high.
- Counter update (each cycle):
  - next = (clear ? 0 : cur) + (cnt_inc[i] ? zero-extended cnt_inc_val slice : 0).
  - A clear and an increment in the same cycle leave the counter equal to the increment, so no event is lost.
  - Without the optional feature, the sum wraps modulo 2^CNT_WIDTH.
- Writes:
  - R/W register: each byte updates only where the corresponding be bit is 1.
  - Writes to RO or counter offsets are acked with no effect and no error.
  - Unmapped write: acked with error=1.
- Outputs: cnt_value and rw_reg reflect register state, with no extra latency.
- Reset mid-transaction: a pending ack is dropped. The master re-issues the transaction after reset.

Optional Feature:
- Macro: OPL_STAT_REGS_SATURATE_EN.
- When defined: if cur + inc would exceed 2^CNT_WIDTH−1, the counter holds at all-ones until it is cleared.
- When undefined: the counter wraps modulo 2^CNT_WIDTH.
- Either way, the clear-plus-increment rule above still applies.

Test Plan:
- Reset, then read 0x000 and 0x004 → rdack one cycle after cs; data=ID_VALUE, then VERSION_VALUE; error=0.
- Hold cs high for 5 cycles on a read of 0x100 → exactly one rdack pulse; counter 0 cleared once. Deassert cs, re-assert → second ack.
- Load counter 1=48'h1234_0000_0005 via increments, read 0x108 then 0x10C → 32'h0000_0005, then 32'h0000_1234; with CLR_ON_READ[1]=1, cnt_value slice 1=0.
- Pulse cnt_inc[0] with cnt_inc_val=7 in the same cycle as a read of 0x100 (counter=10) → read returns 10 and counter becomes 7.
- Write 32'hAABBCCDD with be=4'b0101 to 0x200 (RW_DEFAULT=0) → rw_reg[31:0]=32'h00BB00DD. Write to 0x3F0 → wrack with error=1; read 0x3F0 → 32'hDEADBEEF with error=1.
- CNT_WIDTH=8, counter=250, increment by 10 → without the macro the counter reads 4; with OPL_STAT_REGS_SATURATE_EN it reads 255.

Source files
------------

// File: rtl/opl_stat_regs.sv
// opl_stat_regs: counter and R/W register block on the IPIF-style bus; `define OPL_STAT_REGS_SATURATE_EN to saturate counters instead of wrapping
module opl_stat_regs #(
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_CNT = 8,
  parameter int CNT_WIDTH = 48,
  parameter int INC_WIDTH = 16,
  parameter logic [31:0] CLR_ON_READ = {32{1'b1}},
  parameter int NUM_RW = 4,
  parameter logic [31:0] RW_DEFAULT = 32'h0,
  parameter logic [31:0] ID_VALUE = 32'h0,
  parameter logic [31:0] VERSION_VALUE = 32'h1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           bus2ip_cs,
  input  logic                           bus2ip_rnw,
  input  logic [ADDR_WIDTH-1:0]          bus2ip_addr,
  input  logic [31:0]                    bus2ip_data,
  input  logic [3:0]                     bus2ip_be,
  output logic [31:0]                    ip2bus_data,
  output logic                           ip2bus_rdack,
  output logic                           ip2bus_wrack,
  output logic                           ip2bus_error,
  input  logic [NUM_CNT-1:0]             cnt_inc,
  input  logic [NUM_CNT*INC_WIDTH-1:0]   cnt_inc_val,
  output logic [NUM_CNT*CNT_WIDTH-1:0]   cnt_value,
  output logic [NUM_RW*32-1:0]           rw_reg
);
  logic armed, fire, rd, wr, lo_rd;
  logic is_id, is_ver, is_clr, in_cnt, in_rw, hit_cnt, hit_rw, mapped;
  logic [ADDR_WIDTH-1:0] a;
  logic [63:0] cval;
  logic [31:0] rw_q, rdata, snap;
  logic [NUM_CNT-1:0] clr;
  logic [NUM_CNT-1:0][CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [NUM_RW-1:0][31:0] rw, rw_nxt;
`ifdef OPL_STAT_REGS_SATURATE_EN
  logic [CNT_WIDTH:0] sum;
`endif
  assign a = bus2ip_addr & ~ADDR_WIDTH'(3);
  assign fire = bus2ip_cs & armed;
  assign rd = fire & bus2ip_rnw;
  assign wr = fire & ~bus2ip_rnw;
  assign is_id = a == ADDR_WIDTH'(0);
  assign is_ver = a == ADDR_WIDTH'(4);
  assign is_clr = a == ADDR_WIDTH'(8);
  assign in_cnt = a[ADDR_WIDTH-1:8] == (ADDR_WIDTH-8)'(1);
  assign in_rw = a[ADDR_WIDTH-1:8] == (ADDR_WIDTH-8)'(2);
  always_comb begin
    hit_cnt = 1'b0;
    cval = '0;
    hit_rw = 1'b0;
    rw_q = '0;
    for (int i = 0; i < NUM_CNT; i++)
      if (in_cnt && a[7:3] == 5'(i)) begin
        hit_cnt = 1'b1;
        cval = 64'(cnt[i]);
      end
    for (int j = 0; j < NUM_RW; j++)
      if (in_rw && a[7:2] == 6'(j)) begin
        hit_rw = 1'b1;
        rw_q = rw[j];
      end
  end
  assign lo_rd = rd & hit_cnt & ~a[2];
  assign mapped = is_id | is_ver | is_clr | hit_cnt | hit_rw;
  assign rdata = is_id ? ID_VALUE : is_ver ? VERSION_VALUE : is_clr ? 32'h0 :
                 hit_cnt ? (a[2] ? snap : cval[31:0]) : hit_rw ? rw_q : 32'hDEADBEEF;
  always_comb begin
    clr = '0;
    cnt_nxt = cnt;
`ifdef OPL_STAT_REGS_SATURATE_EN
    sum = '0;
`endif
    for (int i = 0; i < NUM_CNT; i++) begin
      clr[i] = (wr & is_clr & bus2ip_data[i] & bus2ip_be[i/8]) |
               (lo_rd & (a[7:3] == 5'(i)) & CLR_ON_READ[i]);
`ifdef OPL_STAT_REGS_SATURATE_EN
      sum = (CNT_WIDTH+1)'(clr[i] ? {CNT_WIDTH{1'b0}} : cnt[i]) +
            (cnt_inc[i] ? (CNT_WIDTH+1)'(cnt_inc_val[i*INC_WIDTH +: INC_WIDTH]) : {(CNT_WIDTH+1){1'b0}});
      cnt_nxt[i] = sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
`else
      cnt_nxt[i] = (clr[i] ? {CNT_WIDTH{1'b0}} : cnt[i]) +
                   (cnt_inc[i] ? CNT_WIDTH'(cnt_inc_val[i*INC_WIDTH +: INC_WIDTH]) : {CNT_WIDTH{1'b0}});
`endif
    end
  end
  always_comb begin
    rw_nxt = rw;
    for (int j = 0; j < NUM_RW; j++)
      for (int b = 0; b < 4; b++)
        rw_nxt[j][8*b +: 8] = (wr && hit_rw && a[7:2] == 6'(j) && bus2ip_be[b]) ?
                              bus2ip_data[8*b +: 8] : rw[j][8*b +: 8];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      armed <= 1'b1;
      ip2bus_data <= 32'hDEADBEEF;
      ip2bus_rdack <= 1'b0;
      ip2bus_wrack <= 1'b0;
      ip2bus_error <= 1'b0;
      snap <= '0;
      cnt <= '0;
      rw <= {NUM_RW{RW_DEFAULT}};
    end else begin
      armed <= ~bus2ip_cs;
      ip2bus_rdack <= rd;
      ip2bus_wrack <= wr;
      ip2bus_error <= fire & ~mapped;
      if (rd) ip2bus_data <= rdata;
      if (lo_rd) snap <= cval[63:32];
      cnt <= cnt_nxt;
      rw <= rw_nxt;
    end
  end
  assign cnt_value = cnt;
  assign rw_reg = rw;
endmodule
